// File: rtl/vector_reverse_stream_if.sv
// Valid/ready stream bundle for vector_reverse_stream: input word plus mode,
// and the permuted output word.
interface vector_reverse_stream_if #(
  parameter int WIDTH = 100
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master: the surrounding system (producer + consumer); slave: the block
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/vector_reverse_stream.sv
// Pipelined selectable bit/group permutation on a valid/ready stream, with a
// 2-entry skid buffer so in_ready is registered and throughput is one word/cycle.
module vector_reverse_stream #(
  parameter int WIDTH = 100,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  vector_reverse_stream_if.slave s,
  output logic [CNT_W-1:0]       word_count
);

  localparam int unsigned NG = WIDTH / GROUP;

  if ((WIDTH < 2) || (GROUP < 1) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
    $error("vector_reverse_stream: need WIDTH >= 2 and WIDTH a multiple of GROUP");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             in_ready_q;
  logic [WIDTH-1:0] m_q, s_q;
  logic [WIDTH-1:0] perm;
  logic             in_fire, out_fire, out_valid;
  logic             load_m_perm, load_m_skid, load_s;

  always_comb begin
    perm = '0;
    case (s.in_mode)
      2'd0: perm = s.in_data;
      2'd1: begin
        for (int unsigned i = 0; i < WIDTH; i++)
          perm[i] = s.in_data[WIDTH-1-i];
      end
      2'd2: begin
        for (int unsigned g = 0; g < NG; g++)
          for (int unsigned k = 0; k < GROUP; k++)
            perm[g*GROUP+k] = s.in_data[g*GROUP+GROUP-1-k];
      end
      default: begin
        for (int unsigned g = 0; g < NG; g++)
          for (int unsigned k = 0; k < GROUP; k++)
            perm[g*GROUP+k] = s.in_data[(NG-1-g)*GROUP+k];
      end
    endcase
  end

  assign out_valid = (state != EMPTY);
  assign in_fire   = s.in_valid & in_ready_q;
  assign out_fire  = out_valid & s.out_ready;

  always_comb begin
    state_n     = state;
    load_m_perm = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_n     = ONE;
          load_m_perm = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_m_perm = 1'b1;
        end else if (in_fire) begin
          state_n = FULL;
          load_s  = 1'b1;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_fire) begin
          state_n     = ONE;
          load_m_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
      if (load_m_perm) m_q <= perm;
      else if (load_m_skid) m_q <= s_q;
      if (load_s) s_q <= perm;
      if (out_fire) word_count <= word_count + CNT_W'(1);
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid;
  assign s.out_data  = m_q;

endmodule

// File: tb/tb_vector_reverse_stream.sv
// Directed bench for vector_reverse_stream: permutations, backpressure,
// throughput, mid-stream reset and counter wrap on three parameterisations.
module tb_vector_reverse_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wc8, wc100;
  logic [3:0]  wcw;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  vector_reverse_stream_if #(.WIDTH(8))   b8 ();
  vector_reverse_stream_if #(.WIDTH(100)) b100 ();
  vector_reverse_stream_if #(.WIDTH(8))   bw ();

  vector_reverse_stream #(.WIDTH(8), .GROUP(4), .CNT_W(16)) dut8 (
    .clk(clk), .reset(rst), .s(b8), .word_count(wc8)
  );
  vector_reverse_stream #(.WIDTH(100), .GROUP(4), .CNT_W(16)) dut100 (
    .clk(clk), .reset(rst), .s(b100), .word_count(wc100)
  );
  vector_reverse_stream #(.WIDTH(8), .GROUP(4), .CNT_W(4)) dutw (
    .clk(clk), .reset(rst), .s(bw), .word_count(wcw)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [7:0] pv_mode_exp [4] = '{8'b1000_0110, 8'b0110_0001, 8'b0001_0110, 8'b0110_1000};

  initial begin
    b8.in_valid = 0; b8.in_data = '0; b8.in_mode = 0; b8.out_ready = 0;
    b100.in_valid = 0; b100.in_data = '0; b100.in_mode = 0; b100.out_ready = 0;
    bw.in_valid = 0; bw.in_data = '0; bw.in_mode = 0; bw.out_ready = 0;

    // reset state
    step();
    rst = 1'b0;
    check("rst_out_valid", b8.out_valid, 1'b0);
    check("rst_in_ready", b8.in_ready, 1'b1);
    check("rst_wc", wc8, 16'd0);
    check("rst_out_data", b8.out_data, 8'h00);

    // permutations, WIDTH=8 GROUP=4, back-to-back
    b8.out_ready = 1;
    for (int m = 0; m < 4; m++) begin
      b8.in_valid = 1; b8.in_data = 8'b1000_0110; b8.in_mode = 2'(m);
      step();
      check($sformatf("perm8_valid_m%0d", m), b8.out_valid, 1'b1);
      check($sformatf("perm8_data_m%0d", m), b8.out_data, pv_mode_exp[m]);
    end
    b8.in_valid = 0;
    step();
    check("perm8_wc", wc8, 16'd4);

    // defaults WIDTH=100 GROUP=4
    do_reset();
    b100.out_ready = 1;
    b100.in_valid = 1; b100.in_data = 100'h1; b100.in_mode = 2'd1;
    step();
    check("w100_m1", b100.out_data, 100'h1 << 99);
    b100.in_mode = 2'd3;
    step();
    check("w100_m3", b100.out_data, 100'h1 << 96);
    b100.in_mode = 2'd2;
    step();
    check("w100_m2", b100.out_data, 100'h8);
    b100.in_valid = 0;
    step();
    check("w100_drain", b100.out_valid, 1'b0);

    // backpressure: A, B accepted, C held off
    do_reset();
    b8.out_ready = 0;
    b8.in_valid = 1; b8.in_data = 8'hA1; b8.in_mode = 0;
    step();
    check("bp_ready_after_a", b8.in_ready, 1'b1);
    b8.in_data = 8'hB2;
    step();
    check("bp_ready_after_b", b8.in_ready, 1'b0);
    b8.in_data = 8'hC3;
    step();
    check("bp_held_ready", b8.in_ready, 1'b0);
    check("bp_hold_a", b8.out_data, 8'hA1);
    check("bp_hold_valid", b8.out_valid, 1'b1);
    b8.out_ready = 1;
    step();
    check("bp_out_b", b8.out_data, 8'hB2);
    check("bp_wc1", wc8, 16'd1);
    step();
    b8.in_valid = 0;
    check("bp_out_c", b8.out_data, 8'hC3);
    check("bp_c_valid", b8.out_valid, 1'b1);
    step();
    check("bp_empty", b8.out_valid, 1'b0);
    check("bp_wc3", wc8, 16'd3);

    // throughput: 50 words, one per cycle
    do_reset();
    b8.out_ready = 1;
    for (int i = 0; i < 50; i++) begin
      b8.in_valid = 1; b8.in_data = 8'(i + 10); b8.in_mode = 0;
      check($sformatf("tp_ready_%0d", i), b8.in_ready, 1'b1);
      step();
      check($sformatf("tp_data_%0d", i), {b8.out_valid, b8.out_data}, {1'b1, 8'(i + 10)});
    end
    b8.in_valid = 0;
    step();
    check("tp_wc50", wc8, 16'd50);

    // reset while FULL, input still offered during reset
    do_reset();
    b8.out_ready = 0;
    b8.in_valid = 1; b8.in_data = 8'h11;
    step();
    b8.in_data = 8'h22;
    step();
    check("mr_full", b8.in_ready, 1'b0);
    b8.in_data = 8'h33;
    rst = 1'b1;
    step();
    rst = 1'b0;
    b8.in_valid = 0;
    check("mr_out_valid", b8.out_valid, 1'b0);
    check("mr_in_ready", b8.in_ready, 1'b1);
    check("mr_wc", wc8, 16'd0);
    check("mr_out_data", b8.out_data, 8'h00);
    step();
    check("mr_still_empty", b8.out_valid, 1'b0);
    b8.out_ready = 1;
    b8.in_valid = 1; b8.in_data = 8'h5A;
    step();
    b8.in_valid = 0;
    check("mr_first", {b8.out_valid, b8.out_data}, {1'b1, 8'h5A});
    step();
    check("mr_wc1", wc8, 16'd1);

    // counter wrap with CNT_W=4: 17 handshakes -> 1
    do_reset();
    bw.out_ready = 1;
    bw.in_valid = 1; bw.in_data = 8'h3C; bw.in_mode = 2'd1;
    for (int i = 0; i < 16; i++) step();
    check("wrap_15", wcw, 4'd15);
    step();
    bw.in_valid = 0;
    check("wrap_0", wcw, 4'd0);
    check("wrap_data", bw.out_data, 8'h3C);
    step();
    check("wrap_1", wcw, 4'd1);
    check("wrap_empty", bw.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_reverse_stream.md
Name: vector_reverse_stream

Overview:
- Parametrised, pipelined successor to the fixed 100-bit combinational bit reverser.
- Accepts WIDTH-bit words on a valid/ready stream and applies a per-word selectable permutation: pass, full bit reverse, bit reverse within GROUP-bit groups, or group-order reverse.
- Emits the results on a valid/ready output stream through a 2-entry skid buffer, giving full throughput with a registered in_ready.
- Sits between stream producers and consumers that need endian or bit-order conversion.

Parameters:
- WIDTH, 100, data word width in bits; must be >= 2.
- GROUP, 4, group size for modes 2 and 3; WIDTH % GROUP must be 0 (elaboration-time assertion).
- CNT_W, 16, width of the output-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_mode are valid.
- in_ready  output  1  block can accept a word; driven directly from a register.
- in_data  input  WIDTH  input word.
- in_mode  input  2  permutation select, sampled with in_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  permuted word.
- word_count  output  CNT_W  number of output handshakes since reset; wraps modulo 2^CNT_W.

Behaviour:
- Input handshake: in_fire = in_valid & in_ready. Output handshake: out_fire = out_valid & out_ready.
- Permutation is computed combinationally on in_data at in_fire. Only the permuted word is stored; the mode is not stored.
- mode 0: out[i] = in[i].
- mode 1: out[i] = in[WIDTH-1-i].
- mode 2: for group g and offset k, out[g*GROUP+k] = in[g*GROUP+GROUP-1-k].
- mode 3: out[g*GROUP+k] = in[(WIDTH/GROUP-1-g)*GROUP+k].
- Storage: main register M drives out_data; skid register S.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M valid; out_valid=1, in_ready=1.
  - FULL: M and S valid; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + in_fire -> ONE; M <= perm. Latency is 1 cycle, input fire to out_valid.
  - ONE + in_fire + out_fire -> ONE; M <= perm.
  - ONE + in_fire, no out_fire -> FULL; S <= perm.
  - ONE + out_fire, no in_fire -> EMPTY.
  - FULL + out_fire -> ONE; M <= S. No input accepted in FULL.
  - Any other combination holds state.
- Ordering: words leave in strict acceptance order. No word is dropped or duplicated.
- out_data is stable while out_valid=1 and out_ready=0.
- in_valid with in_ready=0 has no effect. Producer must hold in_data/in_mode until in_fire.
- word_count increments by 1 on every out_fire; wraps from 2^CNT_W-1 to 0.
- Reset (synchronous, takes priority over all handshakes, including mid-stream):
  - state <= EMPTY; out_valid=0; in_ready=1 in the cycle after reset deasserts (register reset value 1).
  - word_count=0; M and S cleared to 0, so out_data=0.
  - Words held at reset are discarded.
- While reset is high, in_fire is ignored and out_valid remains 0.

Test Plan:
- Permutation check, WIDTH=8, GROUP=4, out_ready=1, in_data=8'b1000_0110:
  - mode0 -> 8'b1000_0110
  - mode1 -> 8'b0110_0001
  - mode2 -> 8'b0001_0110
  - mode3 -> 8'b0110_1000
  - Each result appears one cycle after its in_fire.
- Defaults WIDTH=100, GROUP=4: in_data=100'h1, mode1 -> out_data has only bit 99 set; mode3 -> out_data = 100'h1 << 96.
- Backpressure: hold out_ready=0 and send 3 words A,B,C back-to-back. Required: A and B accepted, in_ready=0 from the cycle after B is accepted, C held off. Then raise out_ready: outputs A,B,C in order, one per cycle; word_count=3.
- Throughput: in_valid=1 and out_ready=1 continuously for 50 words -> one word out per cycle after 1-cycle latency, in_ready never drops; word_count=50.
- Reset mid-operation in FULL state: next cycle out_valid=0, in_ready=1, word_count=0, out_data=0. The first word after reset is the first output.
- Counter wrap, CNT_W=4: 17 output handshakes -> word_count=1.
